// File: rtl/led_pkg.sv
// Shared state encoding and default timing for the LED strand driver.
package led_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    LATCH = 2'd3
  } led_state_t;

  localparam int DEF_NUM_LEDS          = 50;
  localparam int DEF_LED_ADDRESS_WIDTH = 10;
  localparam int DEF_BIT_PERIOD_CYCLES = 125;
  localparam int DEF_HIGH_0_CYCLES     = 35;
  localparam int DEF_HIGH_1_CYCLES     = 70;
  localparam int DEF_LATCH_CYCLES      = 6000;
  localparam int BITS_PER_LED          = 24;

  // Counter width able to hold 0..max_count-1, never narrower than one bit.
  function automatic int cnt_width(input int max_count);
    return (max_count > 1) ? $clog2(max_count) : 1;
  endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// One encoded bit per start: a BIT_PERIOD_CYCLES window, high for the first
// HIGH_x_CYCLES of it, where x is the bit presented on bit_value.
module led_bit_encoder
  import led_pkg::*;
#(
  parameter int BIT_PERIOD_CYCLES = DEF_BIT_PERIOD_CYCLES,
  parameter int HIGH_0_CYCLES     = DEF_HIGH_0_CYCLES,
  parameter int HIGH_1_CYCLES     = DEF_HIGH_1_CYCLES
) (
  input  logic clk_led,
  input  logic rst,
  input  logic start,
  input  logic bit_value,
  output logic bit_done,
  output logic pulse
);

  localparam int CW = cnt_width(BIT_PERIOD_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_PERIOD_CYCLES - 1);
  localparam logic [CW:0]   HIGH_0   = (CW+1)'(HIGH_0_CYCLES);
  localparam logic [CW:0]   HIGH_1   = (CW+1)'(HIGH_1_CYCLES);
  localparam logic [CW:0]   ONE      = (CW+1)'(1);

  logic [CW-1:0] cnt;
  logic [CW:0]   cnt_next;
  logic [CW:0]   high_len;
  logic          active;

  assign cnt_next = {1'b0, cnt} + ONE;
  assign high_len = bit_value ? HIGH_1 : HIGH_0;
  assign bit_done = active && (cnt == LAST_CNT);

  // The high phase begins on the start edge itself, so both high times must be non-zero.
  always_ff @(posedge clk_led) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      pulse  <= 1'b0;
    end else if (start) begin
      cnt    <= '0;
      active <= 1'b1;
      pulse  <= 1'b1;
    end else if (bit_done) begin
      cnt    <= '0;
      active <= 1'b0;
      pulse  <= 1'b0;
    end else if (active) begin
      cnt    <= cnt_next[CW-1:0];
      pulse  <= (cnt_next < high_len);
    end
  end

endmodule

// File: rtl/led_strip_driver.sv
// Fetches one colour per LED from upstream and streams the whole strand, then
// holds the line low long enough for the LEDs to latch.
//
// state | meaning
// IDLE  | line low, address 0, waiting for refresh_enable
// FETCH | waiting for color_valid on the current address
// SHIFT | 24 bits of the loaded LED on the line, MSB first
// LATCH | line low for LATCH_CYCLES, then frame_done
module led_strip_driver
  import led_pkg::*;
#(
  parameter int NUM_LEDS          = DEF_NUM_LEDS,
  parameter int LED_ADDRESS_WIDTH = DEF_LED_ADDRESS_WIDTH,
  parameter int BIT_PERIOD_CYCLES = DEF_BIT_PERIOD_CYCLES,
  parameter int HIGH_0_CYCLES     = DEF_HIGH_0_CYCLES,
  parameter int HIGH_1_CYCLES     = DEF_HIGH_1_CYCLES,
  parameter int LATCH_CYCLES      = DEF_LATCH_CYCLES
) (
  input  logic                         clk_led,
  input  logic                         rst,
  input  logic                         refresh_enable,
  input  logic [7:0]                   green_in,
  input  logic [7:0]                   red_in,
  input  logic [7:0]                   blue_in,
  input  logic                         color_valid,
  output logic [LED_ADDRESS_WIDTH-1:0] next_led_request_address,
  output logic                         strand_out,
  output logic                         busy,
  output logic                         frame_done
);

  localparam int BW = cnt_width(BITS_PER_LED);
  localparam int LW = cnt_width(LATCH_CYCLES);
  localparam logic [LED_ADDRESS_WIDTH-1:0] LAST_ADDR  = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);
  localparam logic [LED_ADDRESS_WIDTH-1:0] ADDR_ONE   = LED_ADDRESS_WIDTH'(1);
  localparam logic [BW-1:0]                LAST_BIT   = BW'(BITS_PER_LED - 1);
  localparam logic [BW-1:0]                BIT_ONE    = BW'(1);
  localparam logic [LW-1:0]                LATCH_LOAD = LW'(LATCH_CYCLES - 1);
  localparam logic [LW-1:0]                LATCH_ONE  = LW'(1);

  led_state_t  state;
  logic [23:0] shift_reg;
  logic [BW-1:0] bit_idx;
  logic [LW-1:0] latch_cnt;
  logic        last_led;
  logic        bit_done;
  logic        led_end;
  logic        load;
  logic        enc_start;

  // A load can also happen on the final cycle of the previous LED, which keeps
  // consecutive LEDs back-to-back on the line.
  always_comb begin
    led_end   = 1'b0;
    load      = 1'b0;
    enc_start = 1'b0;
    led_end   = (state == SHIFT) && bit_done && (bit_idx == LAST_BIT);
    load      = color_valid && ((state == FETCH) || (led_end && !last_led));
    enc_start = load || ((state == SHIFT) && bit_done && !led_end);
  end

  always_ff @(posedge clk_led) begin
    if (rst) begin
      state                    <= IDLE;
      next_led_request_address <= '0;
      shift_reg                <= '0;
      bit_idx                  <= '0;
      latch_cnt                <= '0;
      last_led                 <= 1'b0;
      frame_done               <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (load) begin
        shift_reg <= {green_in, red_in, blue_in};
        bit_idx   <= '0;
        last_led  <= (next_led_request_address == LAST_ADDR);
        if (next_led_request_address < LAST_ADDR)
          next_led_request_address <= next_led_request_address + ADDR_ONE;
        state     <= SHIFT;
      end else begin
        case (state)
          IDLE: begin
            next_led_request_address <= '0;
            if (refresh_enable)
              state <= FETCH;
          end
          FETCH: begin
            state <= FETCH;
          end
          SHIFT: begin
            if (bit_done) begin
              if (led_end) begin
                if (last_led) begin
                  state                    <= LATCH;
                  latch_cnt                <= LATCH_LOAD;
                  next_led_request_address <= '0;
                end else begin
                  state <= FETCH;
                end
              end else begin
                shift_reg <= {shift_reg[22:0], 1'b0};
                bit_idx   <= bit_idx + BIT_ONE;
              end
            end
          end
          LATCH: begin
            // refresh_enable only matters here, so a frame is never cut short.
            if (latch_cnt == '0) begin
              frame_done <= 1'b1;
              state      <= refresh_enable ? FETCH : IDLE;
            end else begin
              latch_cnt <= latch_cnt - LATCH_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

  led_bit_encoder #(
    .BIT_PERIOD_CYCLES(BIT_PERIOD_CYCLES),
    .HIGH_0_CYCLES    (HIGH_0_CYCLES),
    .HIGH_1_CYCLES    (HIGH_1_CYCLES)
  ) u_encoder (
    .clk_led  (clk_led),
    .rst      (rst),
    .start    (enc_start),
    .bit_value(shift_reg[23]),
    .bit_done (bit_done),
    .pulse    (strand_out)
  );

endmodule

// File: tb/tb_led_strip_driver.sv
// Bench for led_strip_driver: a waveform-queue model of the strand checked every
// cycle, an upstream colour source, and pulse-width decoding of the line.
module tb_led_strip_driver;

  localparam int N  = 3;
  localparam int BP = 10;
  localparam int H0 = 3;
  localparam int H1 = 7;
  localparam int LT = 20;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          refresh_enable;
  logic [7:0]    green_in, red_in, blue_in;
  logic          color_valid;
  logic [AW-1:0] addr;
  logic          strand_out, busy, frame_done;

  int n_err    = 0;
  int n_checks = 0;
  bit chk_en   = 0;

  led_strip_driver #(
    .NUM_LEDS(N), .LED_ADDRESS_WIDTH(AW), .BIT_PERIOD_CYCLES(BP),
    .HIGH_0_CYCLES(H0), .HIGH_1_CYCLES(H1), .LATCH_CYCLES(LT)
  ) dut (
    .clk_led(clk), .rst(rst), .refresh_enable(refresh_enable),
    .green_in(green_in), .red_in(red_in), .blue_in(blue_in),
    .color_valid(color_valid), .next_led_request_address(addr),
    .strand_out(strand_out), .busy(busy), .frame_done(frame_done)
  );

  initial forever #5 clk = ~clk;

  // ---------------- upstream colour source ----------------
  logic [7:0] tab_g[N], tab_r[N], tab_b[N];
  int hold_off = 0;
  int vdelay   = 0;

  initial begin : upstream
    logic [AW-1:0] last_addr;
    int wait_cnt;
    int idx;
    last_addr = '0;
    wait_cnt  = 1000;
    color_valid = 1'b0;
    green_in = '0; red_in = '0; blue_in = '0;
    forever begin
      @(posedge clk);
      #1;
      if (addr !== last_addr) begin
        last_addr = addr;
        wait_cnt  = 0;
      end else if (wait_cnt < 1000) begin
        wait_cnt++;
      end
      color_valid = (hold_off == 0) && (wait_cnt >= vdelay);
      idx = int'(addr) % N;
      if (color_valid) begin
        green_in = tab_g[idx]; red_in = tab_r[idx]; blue_in = tab_b[idx];
      end else begin
        green_in = 8'($urandom); red_in = 8'($urandom); blue_in = 8'($urandom);
      end
    end
  end

  // ---------------- reference model: queue of future line samples ----------------
  localparam int M_IDLE = 0, M_FETCH = 1, M_SEND = 2, M_LATCH = 3;
  int m_mode  = M_IDLE;
  bit m_q[$];
  int m_addr  = 0;
  bit m_out   = 0;
  bit m_fd    = 0;
  bit m_last  = 0;
  int m_latch = 0;

  task automatic m_load();
    logic [23:0] w;
    int hi;
    w = {green_in, red_in, blue_in};
    for (int b = 23; b >= 0; b--) begin
      hi = w[b] ? H1 : H0;
      for (int k = 0; k < BP; k++) m_q.push_back(k < hi);
    end
    m_last = (m_addr == N - 1);
    if (m_addr < N - 1) m_addr++;
    m_mode = M_SEND;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_q.delete(); m_addr = 0; m_fd = 0; m_out = 0; m_last = 0; m_latch = 0;
    end else begin
      m_fd = 0;
      case (m_mode)
        M_IDLE:  if (refresh_enable) m_mode = M_FETCH;
        M_FETCH: if (color_valid) m_load();
        M_SEND: begin
          if (m_q.size() == 0) begin
            if (m_last) begin
              m_mode = M_LATCH; m_latch = LT; m_addr = 0;
            end else if (color_valid) begin
              m_load();
            end else begin
              m_mode = M_FETCH;
            end
          end
        end
        default: begin
          m_latch--;
          if (m_latch == 0) begin
            m_fd   = 1;
            m_mode = refresh_enable ? M_FETCH : M_IDLE;
          end
        end
      endcase
      m_out = (m_q.size() > 0) ? m_q.pop_front() : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (strand_out !== m_out || busy !== (m_mode != M_IDLE) ||
          addr !== AW'(m_addr) || frame_done !== m_fd) begin
        n_err++;
        $display("FAIL cycle_compare t=%0t strand/busy/addr/frame_done got %b/%b/%0d/%b want %b/%b/%0d/%b",
                 $time, strand_out, busy, addr, frame_done, m_out, (m_mode != M_IDLE), m_addr, m_fd);
      end
    end
  end

  // ---------------- line monitor: pulse decoding and gap measurement ----------------
  bit dec_q[$];
  int cyc = 0, run = 0, low_len = 0, last_high = 0, last_gap = 0, last_low = 0;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        run = 0; low_len = 0;
      end else if (strand_out) begin
        if (run == 0) last_low = low_len;
        run++; low_len = 0; last_high = cyc;
      end else begin
        if (run > 0) begin
          n_checks++;
          if (run == H1) dec_q.push_back(1'b1);
          else if (run == H0) dec_q.push_back(1'b0);
          else begin
            n_err++;
            $display("FAIL pulse_width t=%0t got %0d cycles want %0d or %0d", $time, run, H0, H1);
          end
        end
        run = 0; low_len++;
      end
      if (frame_done) last_gap = cyc - last_high;
    end
  end

  // ---------------- helpers ----------------
  task automatic check1(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic wait_frame_done(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    n_checks++; n_err++;
    $display("FAIL %s_frame_done_timeout: got no pulse want one within 3000 cycles", tag);
  endtask

  task automatic wait_addr(input int a);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (addr == AW'(a)) return;
    end
    n_checks++; n_err++;
    $display("FAIL addr_timeout: got %0d want %0d within 3000 cycles", addr, a);
  endtask

  task automatic wait_high(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (strand_out) return;
    end
    n_checks++; n_err++;
    $display("FAIL %s_high_timeout: got strand 0 want 1 within 3000 cycles", tag);
  endtask

  task automatic set_tables(input bit fixed);
    for (int i = 0; i < N; i++) begin
      if (fixed) begin
        tab_g[i] = 8'hA5; tab_r[i] = 8'h00; tab_b[i] = 8'hFF;
      end else begin
        tab_g[i] = 8'($urandom); tab_r[i] = 8'($urandom); tab_b[i] = 8'($urandom);
      end
    end
  endtask

  task automatic check_decoded(input string tag);
    logic [23:0] w;
    check1({tag, "_bit_count"}, dec_q.size(), 24 * N);
    if (dec_q.size() == 24 * N) begin
      for (int i = 0; i < N; i++) begin
        w = '0;
        for (int b = 0; b < 24; b++) w = {w[22:0], dec_q.pop_front()};
        check1($sformatf("%s_led%0d_colour", tag, i), w, {tab_g[i], tab_r[i], tab_b[i]});
      end
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    logic [23:0] w;
    rst = 1'b1; refresh_enable = 1'b0;
    set_tables(1'b1);
    repeat (3) @(negedge clk);
    chk_en = 1;
    check1("reset_strand", strand_out, 0);
    check1("reset_busy", busy, 0);
    check1("reset_addr", addr, 0);
    check1("reset_frame_done", frame_done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check1("idle_stays_idle", busy, 0);

    // A5/00/FF on every LED, colour arrives 2 cycles after each address change
    vdelay = 2; dec_q.delete();
    refresh_enable = 1'b1;
    @(negedge clk);
    check1("A_busy_after_start", busy, 1);
    refresh_enable = 1'b0;
    wait_frame_done("A");
    // last high of B0 (a 1), 3-cycle tail, 20 latch cycles, then the pulse cycle
    check1("A_latch_gap", last_gap, 24);
    check1("A_frame_done_addr", addr, 0);
    check_decoded("A");
    w = '0;
    for (int i = 0; i < N; i++) w = w | {tab_g[i], tab_r[i], tab_b[i]};
    check1("A_pattern_literal", w, 24'hA500FF);
    @(negedge clk);
    check1("A_frame_done_width", frame_done, 0);
    check1("A_ends_idle", busy, 0);

    // colour always valid: 72 bits back-to-back
    set_tables(1'b0); vdelay = 0; dec_q.delete();
    refresh_enable = 1'b1;
    @(negedge clk);
    refresh_enable = 1'b0;
    wait_frame_done("B");
    check_decoded("B");

    // colour withheld before LED 1: 3-cycle tail plus 15 extra low cycles
    set_tables(1'b1); vdelay = 0; dec_q.delete();
    refresh_enable = 1'b1;
    wait_addr(1);
    hold_off = 1; refresh_enable = 1'b0;
    repeat (253) @(negedge clk);
    hold_off = 0;
    wait_high("C");
    check1("C_withheld_low_run", last_low, 18);
    wait_frame_done("C");
    check_decoded("C");

    // random colours and upstream delays over back-to-back frames
    for (int f = 0; f < 3; f++) begin
      set_tables(1'b0);
      vdelay = $urandom_range(0, 6);
      refresh_enable = (f < 2);
      wait_frame_done($sformatf("D%0d", f));
    end
    repeat (3) @(negedge clk);
    check1("D_ends_idle", busy, 0);

    // reset in the 4th cycle of a 1 bit
    set_tables(1'b0); tab_g[0] = 8'hFF; vdelay = 1;
    refresh_enable = 1'b1;
    wait_high("E");
    repeat (3) @(negedge clk);
    check1("E_mid_bit_high", strand_out, 1);
    rst = 1'b1;
    @(negedge clk);
    check1("E_reset_strand", strand_out, 0);
    check1("E_reset_busy", busy, 0);
    check1("E_reset_addr", addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check1("E_restart_busy", busy, 1);
    check1("E_restart_addr", addr, 0);
    refresh_enable = 1'b0;
    wait_frame_done("E");

    // refresh dropped while LED 1 is on the line
    set_tables(1'b0); vdelay = $urandom_range(0, 4);
    refresh_enable = 1'b1;
    wait_addr(2);
    refresh_enable = 1'b0;
    wait_frame_done("F");
    repeat (2) @(negedge clk);
    check1("F_ends_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/led_strip_driver.md
LED_STRIP_DRIVER -- requirements
Module: led_strip_driver

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 50, number of LEDs on the strand.
REQ-002 SHALL have parameter LED_ADDRESS_WIDTH, default 10, width of the request address.
REQ-003 SHALL have parameter BIT_PERIOD_CYCLES, default 125, clk_led cycles per encoded bit.
REQ-004 SHALL have parameter HIGH_0_CYCLES, default 35, high time of a 0 bit.
REQ-005 SHALL have parameter HIGH_1_CYCLES, default 70, high time of a 1 bit.
REQ-006 SHALL have parameter LATCH_CYCLES, default 6000, low time that latches the strand.
REQ-007 SHALL have port clk_led, input, 1; sole clock; single clock domain.
REQ-008 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-009 SHALL have port refresh_enable, input, 1; while high, frames repeat back-to-back.
REQ-010 SHALL have ports green_in, red_in, blue_in, input, 8 each; colour for the currently requested LED.
REQ-011 SHALL have port color_valid, input, 1; colour inputs correspond to next_led_request_address.
REQ-012 SHALL have port next_led_request_address, output, LED_ADDRESS_WIDTH; LED index being fetched.
REQ-013 SHALL have port strand_out, output, 1; registered serial data line to the strand.
REQ-014 SHALL have port busy, output, 1; high in any state other than IDLE.
REQ-015 SHALL have port frame_done, output, 1; one-cycle pulse at the end of each latch gap.

Function
REQ-016 SHALL implement the FSM states IDLE, FETCH, SHIFT and LATCH.
REQ-017 IDLE: address 0 and strand_out 0; when refresh_enable=1, go to FETCH on the next cycle.
REQ-018 FETCH: hold the address and strand_out=0; on color_valid=1, load the 24-bit shift register {green_in, red_in, blue_in} and go to SHIFT.
REQ-019 On the load cycle, if address < NUM_LEDS-1, increment the address so the next fetch overlaps transmission.
REQ-020 SHIFT: send the 24 bits MSB first (G7 first, B0 last); each bit lasts exactly BIT_PERIOD_CYCLES.
REQ-021 Within a bit, strand_out SHALL be 1 for the first HIGH_x_CYCLES (x = current bit value) and 0 for the remainder.
REQ-022 Latency: strand_out SHALL go high 1 cycle after the load cycle (registered output).
REQ-023 After bit 23: if the LED just sent was index NUM_LEDS-1, go to LATCH; otherwise go to FETCH, and load in the same cycle when color_valid=1 (no gap).
REQ-024 If color_valid=0 in FETCH, strand_out SHALL stay 0 for as long as needed; there is no timeout.
REQ-025 LATCH: strand_out=0 and address 0 for LATCH_CYCLES cycles; then pulse frame_done and go to FETCH if refresh_enable=1, else to IDLE.
REQ-026 refresh_enable deasserting mid-frame SHALL NOT truncate the frame; it is sampled only at the end of LATCH.
REQ-027 Bit and cycle counters SHALL be sized with $clog2 of their maxima and SHALL wrap only under FSM control.
REQ-028 Colour inputs SHALL be ignored outside the load cycle.

Reset
REQ-029 rst=1 at any time, including mid-bit, SHALL on the next edge set state IDLE, strand_out 0, address 0, busy 0, frame_done 0, and clear the counters and shift register.
REQ-030 rst SHALL take priority over all other inputs.

Structure
REQ-031 The FSM state enum and the default timing constants SHALL live in the shared package led_pkg.
REQ-032 One sub-module, led_bit_encoder, SHALL contain the per-bit period counter and the high/low generation, and SHALL signal bit_done to the FSM.
REQ-033 The block SHALL contain no RAM; colour storage stays upstream.

Verification (NUM_LEDS=3, BIT_PERIOD=10, HIGH_0=3, HIGH_1=7, LATCH=20)
REQ-034 Scenario: upstream returns colour=addr-indexed {8'hA5, 8'h00, 8'hFF} with color_valid 2 cycles after each address change -> each LED's high-pulse widths decode to 10100101 00000000 11111111.
REQ-035 Scenario: color_valid held high -> 72 bits back-to-back with no gap between LEDs; addresses 0,1,2 are requested in order.
REQ-036 Scenario: color_valid withheld 15 cycles before LED 1 -> strand_out stays 0 for 15 extra cycles, then resumes with correct data.
REQ-037 Scenario: end of LED 2 -> exactly 20 cycles low, frame_done high for 1 cycle, address 0.
REQ-038 Scenario: rst asserted in cycle 4 of a 1 bit -> strand_out 0 and busy 0 on the next edge; after release, the frame restarts at LED 0.
REQ-039 Scenario: refresh_enable dropped during LED 1 -> the frame completes, frame_done pulses, FSM ends in IDLE.
